// File: rtl/iq_scan_pkg.sv
// iq_scan_pkg: shared state type, index-width helper and offset-binary helpers for the IQ channel scanner
package iq_scan_pkg;

    // ST_ prefix keeps the state names clear of the SETTLE parameter in the top module
    typedef enum logic {ST_SETTLE, ST_TRACK} state_e;

    // Index width for n entries, never below 1 bit
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Midscale code 2^(w-1); the top narrows it to W bits as its MIDSCALE constant
    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Two's complement to offset binary is an MSB flip
    function automatic logic [31:0] to_offset_binary(input logic [31:0] s, input int w);
        return s ^ midscale(w);
    endfunction

endpackage

// File: rtl/iq_clip_detect.sv
// iq_clip_detect: sticky full-scale detector for one IQ channel
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_i, q_i      : signed I/Q sample of this channel
//   valid_i       : sample strobe of this channel
//   clr_i         : synchronous clear; a new clip in the same cycle wins
//   flag_o        : sticky clip flag
module iq_clip_detect import iq_scan_pkg::*; #(
    parameter int W = 14
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] i_i,
    input  logic [W-1:0] q_i,
    input  logic         valid_i,
    input  logic         clr_i,
    output logic         flag_o
);

    localparam logic [W-1:0] NEG_FS = W'(midscale(W));
    localparam logic [W-1:0] POS_FS = ~NEG_FS;

    logic hit;
    logic flag_q;

    assign hit = valid_i && (i_i == NEG_FS || i_i == POS_FS || q_i == NEG_FS || q_i == POS_FS);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) flag_q <= 1'b0;
        else         flag_q <= hit || (flag_q && !clr_i);
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/iq_channel_scanner.sv
// iq_channel_scanner: routes I or Q of one of NCH channels to the DAC in offset binary, manual or round-robin scan
//   CLK, reset_n       : clock, asynchronous active-low reset
//   i_data, q_data     : NCH packed signed samples, channel k at [k*W +: W]
//   data_valid         : per-channel sample strobe
//   scan_en            : 1 = automatic scan, 0 = manual selection
//   sel_manual         : manual channel index (values >= NCH ignored)
//   iq_sel             : 0 = route I, 1 = route Q
//   dwell_cycles       : TRACK cycles per channel while scanning (0 acts as 1)
//   clip_clr           : clears all sticky clip flags
//   dac_out, dac_valid : offset-binary sample and its one-cycle strobe
//   active_ch          : channel currently routed
//   settling           : high during the midscale settle window
//   frame_marker       : one-cycle pulse when the scan wraps back to channel 0
//   clip_flags         : sticky per-channel clip indicators
module iq_channel_scanner import iq_scan_pkg::*; #(
    parameter  int NCH     = 4,
    parameter  int W       = 14,
    parameter  int DWELL_W = 24,
    parameter  int SETTLE  = 16,
    localparam int IW      = clog2(NCH)
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic [NCH*W-1:0]   i_data,
    input  logic [NCH*W-1:0]   q_data,
    input  logic [NCH-1:0]     data_valid,
    input  logic               scan_en,
    input  logic [IW-1:0]      sel_manual,
    input  logic               iq_sel,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               clip_clr,
    output logic [W-1:0]       dac_out,
    output logic               dac_valid,
    output logic [IW-1:0]      active_ch,
    output logic               settling,
    output logic               frame_marker,
    output logic [NCH-1:0]     clip_flags
);

    localparam int              SET      = (SETTLE < 1) ? 1 : SETTLE;
    localparam int              SCW      = clog2(SET);
    localparam logic [SCW-1:0]  SET_LAST = SCW'(SET - 1);
    localparam logic [W-1:0]    MIDSCALE = W'(midscale(W));
    localparam logic [IW-1:0]   LAST_CH  = IW'(NCH - 1);

    state_e             state_q;
    logic [SCW-1:0]     settle_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [IW-1:0]      active_q, active_d;
    logic [W-1:0]       dac_q;
    logic               dac_valid_q;
    logic               frame_q, frame_d;
    logic               iq_sel_q;
    logic               scan_en_q;

    logic [W-1:0]       sample;
    logic [DWELL_W-1:0] dw_last;
    logic               ev_a, ev_b, ev_c, ev_d, ev_any, step;

    // Mode qualifiers use the registered scan_en so a scan_en toggle and a
    // dwell expiry can coincide and be resolved by priority.
    always_comb begin
        sample   = iq_sel_q ? q_data[active_q*W +: W] : i_data[active_q*W +: W];
        dw_last  = (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
        ev_c     = scan_en != scan_en_q;
        ev_b     = !scan_en_q && int'(sel_manual) < NCH && sel_manual != active_q;
        ev_a     = iq_sel != iq_sel_q;
        ev_d     = scan_en_q && state_q == ST_TRACK && dwell_q >= dw_last;
        ev_any   = ev_a || ev_b || ev_c || ev_d;
        step     = ev_d && !ev_a && !ev_b && !ev_c;
        active_d = ev_c ? active_q :
                   ev_b ? sel_manual :
                   step ? ((active_q == LAST_CH) ? '0 : active_q + 1'b1) : active_q;
        frame_d  = step && active_q == LAST_CH;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SETTLE;
            settle_q    <= '0;
            dwell_q     <= '0;
            active_q    <= '0;
            dac_q       <= MIDSCALE;
            dac_valid_q <= 1'b0;
            frame_q     <= 1'b0;
            iq_sel_q    <= 1'b0;
            scan_en_q   <= 1'b0;
        end else begin
            iq_sel_q    <= iq_sel;
            scan_en_q   <= scan_en;
            active_q    <= active_d;
            frame_q     <= frame_d;
            dac_valid_q <= 1'b0;
            if (ev_any) begin
                state_q  <= ST_SETTLE;
                settle_q <= '0;
                dac_q    <= MIDSCALE;
            end else if (state_q == ST_SETTLE) begin
                dac_q <= MIDSCALE;
                if (settle_q == SET_LAST) begin
                    state_q  <= ST_TRACK;
                    settle_q <= '0;
                    dwell_q  <= '0;
                end else begin
                    settle_q <= settle_q + 1'b1;
                end
            end else begin
                dwell_q <= dwell_q + 1'b1;
                if (data_valid[active_q]) begin
                    dac_q       <= W'(to_offset_binary(32'(sample), W));
                    dac_valid_q <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_clip
        iq_clip_detect #(.W(W)) u_clip (
            .clk_i   (CLK),
            .rst_ni  (reset_n),
            .i_i     (i_data[k*W +: W]),
            .q_i     (q_data[k*W +: W]),
            .valid_i (data_valid[k]),
            .clr_i   (clip_clr),
            .flag_o  (clip_flags[k])
        );
    end

    assign dac_out      = dac_q;
    assign dac_valid    = dac_valid_q;
    assign active_ch    = active_q;
    assign settling     = state_q == ST_SETTLE;
    assign frame_marker = frame_q;

endmodule
